// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-path arbiter.
// Holds the FSM encoding, the byte width and a clog2 helper.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first request above last,
// scanning upward with wrap; one-hot result.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N = 2,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] pick
);

  int idx;

  always_comb begin
    pick = '0;
    idx  = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (pick == '0 && req[idx]) pick[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin burst arbiter sharing the TX FIFO push port
// between N_REQ byte-stream requesters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int BURST_MAX = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    fifo_full,
  output logic                    fifo_push,
  output logic [DATA_W-1:0]       fifo_wdata,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam int LG_W  = clog2(N_REQ);
  localparam int CNT_W = clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [LG_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  pick;
  logic [LG_W-1:0]   pick_idx;

  rr_pick #(
    .N (N_REQ),
    .W (LG_W)
  ) u_pick (
    .req  (req_valid),
    .last (last_q),
    .pick (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick[i]) pick_idx = LG_W'(i);
    end
  end

  // In XFER the owner is always last_q, so it doubles as the mux select.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (!rst) begin
          req_ready[last_q] = ~fifo_full;
          fifo_push = req_valid[last_q] & ~fifo_full;
        end
        if (fifo_push) begin
          fifo_wdata = req_data[last_q*DATA_W +: DATA_W];
          cnt_d      = cnt_q + 1'b1;
          if (req_last[last_q] || cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LG_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_XFER);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued requesters, a push
// log, and hand-computed expected push sequences.
module tb_uart_tx_arbiter;

  localparam int N = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_last;
  logic [N-1:0] req_ready;
  logic         fifo_full;
  logic         fifo_push;
  logic [7:0]   fifo_wdata;
  logic [N-1:0] grant;
  logic         busy;

  uart_tx_arbiter #(
    .N_REQ     (N),
    .BURST_MAX (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_push  (fifo_push),
    .fifo_wdata (fifo_wdata),
    .grant      (grant),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  qd [N][$];
  logic        ql [N][$];
  logic [31:0] log_e [$];
  int          log_c [$];
  logic [31:0] exp_e [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (qd[r].size() > 0) begin
        req_valid[r]       = 1'b1;
        req_data[r*8 +: 8] = qd[r][0];
        req_last[r]        = ql[r][0];
      end else begin
        req_valid[r]       = 1'b0;
        req_data[r*8 +: 8] = 8'h00;
        req_last[r]        = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] hs;
    hs = req_valid & req_ready;
    if (fifo_push) begin
      log_e.push_back(32'({grant, fifo_wdata}));
      log_c.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int r = 0; r < N; r++) begin
      if (hs[r]) begin
        void'(qd[r].pop_front());
        void'(ql[r].pop_front());
      end
    end
    drive();
    #1;
  endtask

  task automatic push_msg(input int r, input int base, input int n,
                          input bit last);
    for (int i = 0; i < n; i++) begin
      qd[r].push_back(8'(base + i));
      ql[r].push_back(last && (i == n - 1));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fifo_full = 1'b0;
    for (int r = 0; r < N; r++) begin
      qd[r].delete();
      ql[r].delete();
    end
    drive();
    repeat (2) step();
    rst = 1'b0;
    log_e.delete();
    log_c.delete();
    exp_e.delete();
    #1;
  endtask

  task automatic check_log(input string tag);
    check({tag, "_n"}, 32'(log_e.size()), 32'(exp_e.size()));
    foreach (exp_e[i]) begin
      check($sformatf("%s_%0d", tag, i),
            (i < log_e.size()) ? log_e[i] : 32'hDEAD_BEEF, exp_e[i]);
    end
  endtask

  function automatic logic [31:0] gap(input int i, input int j);
    if (log_c.size() > j) return 32'(log_c[j] - log_c[i]);
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fifo_full = 1'b0;
    drive();
    // T1: reset state, then a two-byte message from requester 0
    repeat (5) begin
      step();
      check("rst_grant", 32'(grant), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_push", 32'(fifo_push), 0);
    end
    push_msg(0, 'h31, 2, 1);
    drive();
    rst = 1'b0;
    #1;
    check("t1_idle_push", 32'(fifo_push), 0);
    check("t1_idle_wdata", 32'(fifo_wdata), 0);
    step();
    check("t1_grant", 32'(grant), 1);
    check("t1_busy", 32'(busy), 1);
    check("t1_push", 32'(fifo_push), 1);
    check("t1_wdata", 32'(fifo_wdata), 'h31);
    check("t1_ready", 32'(req_ready), 1);
    step();
    step();
    check("t1_end_grant", 32'(grant), 0);
    check("t1_end_busy", 32'(busy), 0);
    exp_e = '{32'h131, 32'h132};
    check_log("t1_log");
    check("t1_gap", gap(0, 1), 1);

    // T2: both requesters with 3-byte messages alternate
    do_reset();
    push_msg(0, 'h10, 3, 1);
    push_msg(0, 'h13, 3, 1);
    push_msg(1, 'h20, 3, 1);
    push_msg(1, 'h23, 3, 1);
    drive();
    #1;
    repeat (20) step();
    exp_e = '{32'h110, 32'h111, 32'h112, 32'h220, 32'h221, 32'h222,
              32'h113, 32'h114, 32'h115, 32'h223, 32'h224, 32'h225};
    check_log("t2_log");
    for (int i = 1; i < 12; i++) begin
      check($sformatf("t2_cyc_%0d", i), gap(0, i),
            32'(4 * (i / 3) + i % 3));
    end

    // T3: 40-byte stream without last is cut at 16 bytes
    do_reset();
    push_msg(0, 0, 40, 0);
    push_msg(1, 'hA0, 2, 1);
    drive();
    #1;
    repeat (50) step();
    for (int i = 0; i < 16; i++) exp_e.push_back(32'h100 + 32'(i));
    exp_e.push_back(32'h2A0);
    exp_e.push_back(32'h2A1);
    for (int i = 16; i < 40; i++) exp_e.push_back(32'h100 + 32'(i));
    check_log("t3_log");
    check("t3_hold_grant", 32'(grant), 1);
    check("t3_hold_busy", 32'(busy), 1);
    check("t3_hold_push", 32'(fifo_push), 0);

    // T4: fifo_full stalls the burst for four cycles
    do_reset();
    push_msg(0, 'h50, 5, 1);
    drive();
    #1;
    repeat (3) step();
    fifo_full = 1'b1;
    #1;
    repeat (4) begin
      check("t4_stall_push", 32'(fifo_push), 0);
      check("t4_stall_ready", 32'(req_ready), 0);
      check("t4_stall_grant", 32'(grant), 1);
      check("t4_stall_wdata", 32'(fifo_wdata), 0);
      step();
    end
    fifo_full = 1'b0;
    #1;
    check("t4_resume_push", 32'(fifo_push), 1);
    check("t4_resume_wdata", 32'(fifo_wdata), 'h52);
    repeat (5) step();
    exp_e = '{32'h150, 32'h151, 32'h152, 32'h153, 32'h154};
    check_log("t4_log");
    check("t4_gap", gap(1, 2), 5);

    // T5: reset mid-burst aborts; requester 0 wins again after
    do_reset();
    push_msg(0, 'h60, 5, 1);
    drive();
    #1;
    repeat (3) step();
    rst = 1'b1;
    #1;
    check("t5_rst_push", 32'(fifo_push), 0);
    check("t5_rst_ready", 32'(req_ready), 0);
    step();
    check("t5_rst_grant", 32'(grant), 0);
    check("t5_rst_busy", 32'(busy), 0);
    rst = 1'b0;
    push_msg(1, 'h70, 1, 1);
    drive();
    #1;
    check("t5_idle_push", 32'(fifo_push), 0);
    step();
    check("t5_regrant", 32'(grant), 1);
    repeat (8) step();
    exp_e = '{32'h160, 32'h161, 32'h162, 32'h163, 32'h164, 32'h270};
    check_log("t5_log");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (the TX FIFO push side feeding the uart_tx serializer inside uart_top) between N_REQ byte-stream requesters, e.g. the RX loopback echo path and a status/message generator.
- Grants the path round-robin in bursts: a granted requester keeps ownership until it marks its last byte or hits BURST_MAX bytes.
- Bytes from different requesters are never interleaved within a burst.
- Sits between the requesters and the TX FIFO write port, in the same clock domain.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- BURST_MAX, 16, maximum bytes pushed per grant before forced release (1..256).

Ports:
- clk  input  1  system clock (100 MHz in uart_top).
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  requester i has a byte on req_data slice i.
- req_data  input  8*N_REQ  byte of requester i at bits [8i+7:8i].
- req_last  input  N_REQ  byte of requester i is the final byte of its message.
- req_ready  output  N_REQ  byte of requester i is accepted this cycle.
- fifo_full  input  1  TX FIFO full flag.
- fifo_push  output  1  TX FIFO write strobe.
- fifo_wdata  output  8  TX FIFO write data.
- grant  output  N_REQ  registered one-hot owner; all zero when idle.
- busy  output  1  high while in XFER.

Behaviour:
- Reset (synchronous, active-high):
  - Registered outputs: grant=0, busy=0, state=IDLE, byte count=0.
  - last_grant pointer = N_REQ-1, so requester 0 wins first.
  - Combinational outputs are consequently fifo_push=0, req_ready=0, fifo_wdata=0.
  - rst asserted mid-burst aborts the burst. No push occurs in the reset cycle. Nothing is replayed.
- State IDLE:
  - If any req_valid is high, select the first requester with valid high, scanning upward (with wrap) from last_grant+1.
  - Register grant (one-hot), set last_grant to the winner, clear the count, go to XFER.
  - Arbitration costs exactly 1 cycle; no push happens in IDLE.
  - If no req_valid is high, stay in IDLE.
- State XFER (owner g):
  - Combinational outputs:
    - req_ready[g] = ~fifo_full.
    - fifo_push = req_valid[g] & ~fifo_full.
    - fifo_wdata = req_data[g].
  - All other req_ready bits are 0.
  - Each push increments the byte count.
  - Exit to IDLE on a push with req_last[g]=1 or count==BURST_MAX-1. grant clears on the following edge.
  - When the owner's req_valid drops mid-burst, ownership is held with no timeout.
  - fifo_full high: no push, count unchanged, ownership held.
- fifo_wdata is zero whenever fifo_push is low.
- Throughput: one byte per clk in XFER when not full. Burst overhead is one IDLE cycle.
- Fairness: after owner g is released, every other requester with valid high is served before g again.
- Byte count width is clog2(BURST_MAX+1). With BURST_MAX=1, every push ends the burst.
- req_data and req_last of non-granted requesters are ignored. Valid and last from the owner in the same push cycle are both honoured.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (ST_IDLE, ST_XFER).
  - Byte width constant DATA_W=8.
  - A clog2 helper function.
- One sub-module, rr_pick: combinational round-robin priority selector.
  - Inputs: request vector, last_grant.
  - Output: one-hot winner.
- The FSM, counter and mux stay in uart_tx_arbiter.

Test Plan:
1. Reset → grant=0, busy=0, fifo_push=0 for 5 cycles. Release rst, then req_valid=2'b01 with bytes 0x31,0x32 (last on 0x32) → grant=01 one cycle later, pushes 0x31 then 0x32 on consecutive cycles, back to IDLE.
2. Both requesters valid continuously, each sending 3-byte messages with last on byte 3 → grant order 01,10,01,10. Each burst is 3 contiguous pushes with no interleaving.
3. Requester 0 streams 40 bytes, last never set, BURST_MAX=16 → pushes 16, releases, requester 1 (valid) is served, then requester 0 resumes at byte 17.
4. fifo_full high for 4 cycles mid-burst → no pushes, req_ready=0, grant held. First push after fifo_full falls carries the stalled byte unchanged.
5. rst pulsed for 1 cycle after 2 of 5 bytes → grant=0 next cycle, no push during reset. Re-arbitration restarts with requester 0 priority.
6. Loopback integration: uart_top with RX serial input of 0x31 at 9600 baud plus a second requester → TX serial line shows 0x31 intact (start bit, LSB first, stop bit), never split by the other requester's bytes.
